// File: rtl/bias_bank_add.sv
// ---------------------------------------------------------------------------
// bias_bank_add
//
// Purpose:
//   Programmable per-channel bias stage for the conv adder-tree outputs.
//   A run-time loaded bank holds DEPTH groups of N_adder_tree signed biases.
//   Each accepted beat adds the selected group's biases lane-wise to the
//   adder-tree sums with signed saturation. The result is registered behind
//   a single valid/ready pipeline stage.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   wr_en/wr_grp/
//   wr_lane/wr_data     bias bank write port; out-of-range writes are dropped
//   bias_en             1: add bias, 0: pass lanes through unchanged
//   in_valid/in_ready   input handshake
//   in_grp              bias group used for the beat (out of range -> bias 0)
//   in_data             N lanes, lane i at [DW*(i+1)-1:DW*i]
//   out_valid/out_ready output handshake
//   out_data            biased, saturated lanes (same packing as in_data)
//   sat_flag            per-lane saturation indication for the output beat
//
// Handshake: a beat moves across an interface on a rising clk edge where
//   valid and ready are both high. valid never depends on ready;
//   in_ready = !out_valid | out_ready, so a streaming pipeline has no bubble.
//   The output beat stays unchanged while out_valid & !out_ready.
// ---------------------------------------------------------------------------
module bias_bank_add #(
    parameter int N_adder_tree = 16,
    parameter int DW           = 18,
    parameter int DEPTH        = 4,
    parameter int GW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int LW           = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [GW-1:0]              wr_grp,
    input  logic [LW-1:0]              wr_lane,
    input  logic [DW-1:0]              wr_data,
    input  logic                       bias_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [GW-1:0]              in_grp,
    input  logic [N_adder_tree*DW-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*DW-1:0] out_data,
    output logic [N_adder_tree-1:0]    sat_flag
);

    localparam int N = N_adder_tree;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       bank_q [DEPTH][N];
    logic [DW-1:0]       bank_d [DEPTH][N];
    logic [N*DW-1:0]     out_data_q, out_data_d;
    logic [N-1:0]        sat_q, sat_d;

    logic                accept;
    logic [DW-1:0]       bias_sel [N];
    logic [DW-1:0]       lane_in  [N];
    logic [DW:0]         lane_sum [N];
    logic [DW-1:0]       lane_res [N];
    logic [N-1:0]        lane_sat;

    // ---------------------------------------------------------------
    // Handshake and pipeline state
    // ---------------------------------------------------------------
    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ---------------------------------------------------------------
    // Bias bank write. Compared as int so indices beyond DEPTH/N that
    // fit in the port width are recognised and dropped, never aliased.
    // ---------------------------------------------------------------
    always_comb begin
        bank_d = bank_q;
        for (int g = 0; g < DEPTH; g++) begin
            for (int l = 0; l < N; l++) begin
                if (wr_en && (int'(wr_grp) == g) && (int'(wr_lane) == l)) begin
                    bank_d[g][l] = wr_data;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Bias read uses the registered bank, so a same-cycle write to the
    // same group is seen only by later beats. Unmatched group -> bias 0.
    // ---------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bias_sel[i] = '0;
            for (int g = 0; g < DEPTH; g++) begin
                if (int'(in_grp) == g) begin
                    bias_sel[i] = bank_q[g][i];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Lane arithmetic: one extra bit of headroom; overflow is detected
    // when the top two bits of the DW+1 bit sum disagree.
    // ---------------------------------------------------------------
    always_comb begin
        lane_sat = '0;
        for (int i = 0; i < N; i++) begin
            lane_in[i]  = in_data[DW*i +: DW];
            lane_sum[i] = {lane_in[i][DW-1], lane_in[i]} + {bias_sel[i][DW-1], bias_sel[i]};
            lane_res[i] = lane_in[i];
            if (bias_en) begin
                if (lane_sum[i][DW] != lane_sum[i][DW-1]) begin
                    lane_sat[i] = 1'b1;
                    lane_res[i] = lane_sum[i][DW] ? SAT_MIN : SAT_MAX;
                end else begin
                    lane_res[i] = lane_sum[i][DW-1:0];
                end
            end
        end
    end

    always_comb begin
        out_data_d = out_data_q;
        sat_d      = sat_q;
        if (accept) begin
            sat_d = lane_sat;
            for (int i = 0; i < N; i++) begin
                out_data_d[DW*i +: DW] = lane_res[i];
            end
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            sat_q      <= '0;
            for (int g = 0; g < DEPTH; g++) begin
                for (int l = 0; l < N; l++) begin
                    bank_q[g][l] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            bank_q     <= bank_d;
        end
    end

endmodule

// File: tb/tb_bias_bank_add.sv
// ---------------------------------------------------------------------------
// tb_bias_bank_add: directed vectors with hand-computed expectations for
// bias_bank_add. DEPTH=4 with a 3-bit group index so that group 4 (one past
// the bank) can be presented on both the write and the beat ports.
// ---------------------------------------------------------------------------
module tb_bias_bank_add;

    localparam int N     = 16;
    localparam int DW    = 18;
    localparam int DEPTH = 4;
    localparam int GW    = 3;
    localparam int LW    = 4;
    localparam int VW    = N*DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [GW-1:0] wr_grp;
    logic [LW-1:0] wr_lane;
    logic [DW-1:0] wr_data;
    logic          bias_en;
    logic          in_valid;
    logic          in_ready;
    logic [GW-1:0] in_grp;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [N-1:0]  sat_flag;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];

    bias_bank_add #(
        .N_adder_tree(N), .DW(DW), .DEPTH(DEPTH), .GW(GW), .LW(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_grp(wr_grp), .wr_lane(wr_lane), .wr_data(wr_data),
        .bias_en(bias_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_grp(in_grp), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input logic [DW-1:0] x);
        logic [VW-1:0] r;
        r = v;
        r[DW*i +: DW] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int i);
        return v[DW*i +: DW];
    endfunction

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] x);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[DW*i +: DW] = x;
        return r;
    endfunction

    // All driver tasks start and end at posedge+#1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_bias(input logic [GW-1:0] g, input logic [LW-1:0] l, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_grp = g; wr_lane = l; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic send_beat(input logic [GW-1:0] g, input logic [VW-1:0] d, input logic ben);
        in_grp = g; in_data = d; bias_en = ben; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [VW-1:0] v;
        bit            pat [4];
        int            sent;
        int            got;
        bit            model_full;
        bit            exp_rdy;
        bit            do_pop;
        bit            do_push;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 1'b0; wr_en = 1'b0; wr_grp = '0; wr_lane = '0; wr_data = '0;
        bias_en = 1'b0; in_valid = 1'b0; in_grp = '0; in_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", VW'(out_valid), VW'(1'b0));
        check("rst_out_data",  out_data, '0);
        check("rst_sat_flag",  VW'(sat_flag), '0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Empty bank: lanes of 5 pass unchanged with bias enabled
        send_beat(3'd0, splat(18'h00005), 1'b1);
        check("zero_bank_valid", VW'(out_valid), VW'(1'b1));
        check("zero_bank_data",  out_data, splat(18'h00005));

        // Load group 1 and read it back through a zero beat
        wr_bias(3'd1, 4'd0,  18'h0A514);
        wr_bias(3'd1, 4'd15, 18'h2FF6C);
        send_beat(3'd1, '0, 1'b1);
        v = '0;
        v = put(v, 0, 18'h0A514);
        v = put(v, 15, 18'h2FF6C);
        check("load_data", out_data, v);
        check("load_sat",  VW'(sat_flag), '0);

        // Saturation both ways; lane2 sits exactly on the positive limit
        wr_bias(3'd3, 4'd0, 18'h1FF00);
        wr_bias(3'd3, 4'd1, 18'h20100);
        v = '0;
        v = put(v, 0, 18'h00200);
        v = put(v, 1, 18'h3FE00);
        v = put(v, 2, 18'h1FFFF);
        send_beat(3'd3, v, 1'b1);
        check("sat_pos_lane", VW'(lane(out_data, 0)), VW'(18'h1FFFF));
        check("sat_neg_lane", VW'(lane(out_data, 1)), VW'(18'h20000));
        check("sat_edge_lane", VW'(lane(out_data, 2)), VW'(18'h1FFFF));
        check("sat_flags",    VW'(sat_flag), VW'(16'h0003));

        // Stall, then reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_grp    = 3'd0;
        in_data   = splat(18'h00007);
        step();
        check("stall_in_ready", VW'(in_ready), VW'(1'b0));
        check("stall_hold",     VW'(lane(out_data, 1)), VW'(18'h20000));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", VW'(out_valid), VW'(1'b0));
        check("midrst_sat",   VW'(sat_flag), '0);
        check("midrst_data",  out_data, '0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        check("postrst_valid", VW'(out_valid), VW'(1'b0));

        // Bank cleared by reset: groups 1 and 3 now add nothing
        send_beat(3'd1, splat(18'h00005), 1'b1);
        check("clr_grp1", out_data, splat(18'h00005));
        send_beat(3'd3, splat(18'h00005), 1'b1);
        check("clr_grp3", out_data, splat(18'h00005));
        check("clr_sat",  VW'(sat_flag), '0);
        step();

        // Backpressure: 8 beats, out_ready pattern 1,0,0,1
        sent = 0; got = 0; model_full = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_grp    = 3'd0;
            bias_en   = 1'b1;
            in_data   = put('0, 0, DW'(sent + 1));
            #1;
            exp_rdy = !model_full || out_ready;
            check("bp_in_ready",  VW'(in_ready), VW'(exp_rdy));
            check("bp_out_valid", VW'(out_valid), VW'(model_full));
            if (model_full && exp_q.size() > 0)
                check("bp_out_lane0", VW'(lane(out_data, 0)), VW'(exp_q[0]));
            do_pop  = model_full && out_ready;
            do_push = in_valid && exp_rdy;
            if (do_pop) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (do_push) begin
                exp_q.push_back(DW'(sent + 1));
                sent++;
            end
            model_full = do_push || (model_full && !do_pop);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_delivered", VW'(got), VW'(8));
        check("bp_leftover",  VW'(exp_q.size()), '0);
        step();
        check("bp_drained",   VW'(out_valid), VW'(1'b0));

        // Collision: write and beat to group 2 in the same cycle
        wr_en = 1'b1; wr_grp = 3'd2; wr_lane = 4'd3; wr_data = 18'h00010;
        in_valid = 1'b1; in_grp = 3'd2; in_data = '0; bias_en = 1'b1;
        step();
        wr_en = 1'b0; in_valid = 1'b0;
        check("coll_old_bias", VW'(lane(out_data, 3)), VW'(18'h00000));
        send_beat(3'd2, '0, 1'b1);
        check("coll_new_bias", VW'(lane(out_data, 3)), VW'(18'h00010));

        // Bypass: bias ignored, no saturation reported
        v = '0;
        v = put(v, 3, 18'h00123);
        v = put(v, 15, 18'h1FFFF);
        send_beat(3'd2, v, 1'b0);
        check("bypass_data", out_data, v);
        check("bypass_sat",  VW'(sat_flag), '0);

        // Out-of-range write group must not alias onto group 0
        wr_bias(3'd4, 4'd0, 18'h00777);
        send_beat(3'd0, '0, 1'b1);
        check("oob_wr_grp", out_data, '0);

        // Out-of-range beat group: bias 0
        v = splat(18'h2ABCD);
        send_beat(3'd4, v, 1'b1);
        check("oob_in_grp",  out_data, v);
        check("oob_in_sat",  VW'(sat_flag), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
